// File: rtl/pipe_shifter_pkg.sv
// Shared definitions for the two-stage pipelined barrel shifter:
// operation encoding and a constant-evaluable clog2.
package pipe_shifter_pkg;

   typedef enum logic [1:0] {
      MODE_SLL = 2'd0,
      MODE_SRL = 2'd1,
      MODE_SRA = 2'd2,
      MODE_ROR = 2'd3
   } mode_e;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/pipe_shifter_if.sv
// Valid/ready operation and result channels of the pipelined shifter.
// The slave modport is the shifter's view; master is the producer/consumer side.
interface pipe_shifter_if
   import pipe_shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) ();
   localparam int SHAMT_W = clog2(WIDTH);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHAMT_W-1:0] in_shamt;
   logic [1:0]         in_mode;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [TAG_W-1:0]   out_tag;

   modport master (
      output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/pipe_shifter_shift_stage.sv
// Partial barrel shifter: applies shamt bits BIT_LO..BIT_HI (given as a
// right-aligned slice) as a cascade of fixed power-of-two shifts.
module shift_stage
   import pipe_shifter_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int BIT_LO = 0,
   parameter int BIT_HI = 1
) (
   input  logic [WIDTH-1:0]         data_in,
   input  logic [BIT_HI-BIT_LO:0]   shamt,
   input  logic [1:0]               mode,
   input  logic                     sign,
   output logic [WIDTH-1:0]         data_out
);
   localparam int N = BIT_HI - BIT_LO + 1;

   // sign is the original operand MSB, so SRA fills correctly even when
   // data_in is already a partially shifted value.
   function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] m,
                                                 input logic s,
                                                 input int k);
      logic [WIDTH-1:0] fill;
      fill = {WIDTH{s}} & ~({WIDTH{1'b1}} >> k);
      case (m)
         MODE_SLL: return d << k;
         MODE_SRL: return d >> k;
         MODE_SRA: return (d >> k) | fill;
         default:  return (d >> k) | (d << (WIDTH - k));
      endcase
   endfunction

   logic [WIDTH-1:0] acc;

   always_comb begin
      acc = data_in;
      for (int i = 0; i < N; i++) begin
         if (shamt[i]) begin
            acc = shift_by(acc, mode, sign, 1 << (BIT_LO + i));
         end
      end
      data_out = acc;
   end
endmodule

// File: rtl/pipe_shifter.sv
// Two-stage pipelined shifter: S1 applies the low shamt bits, S2 the high
// bits. Valid/ready on both sides, flush drops everything in flight.
module pipe_shifter
   import pipe_shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   pipe_shifter_if.slave  bus
);
   localparam int SHAMT_W = clog2(WIDTH);
   localparam int LO_W    = SHAMT_W / 2;
   localparam int HI_W    = SHAMT_W - LO_W;

   logic             s1_valid_reg;
   logic [WIDTH-1:0] s1_data_reg;
   logic [HI_W-1:0]  s1_shamt_reg;
   logic [1:0]       s1_mode_reg;
   logic             s1_sign_reg;
   logic [TAG_W-1:0] s1_tag_reg;

   logic             s2_valid_reg;
   logic [WIDTH-1:0] s2_data_reg;
   logic [TAG_W-1:0] s2_tag_reg;

   logic             s1_adv;
   logic             s2_adv;
   logic             s1_load;
   logic [WIDTH-1:0] s1_data_next;
   logic [WIDTH-1:0] s2_data_next;

   assign s2_adv       = !s2_valid_reg || bus.out_ready;
   assign s1_adv       = !s1_valid_reg || s2_adv;
   assign bus.in_ready = s1_adv && !flush && !rst;
   assign s1_load      = bus.in_valid && bus.in_ready;

   assign bus.out_valid = s2_valid_reg;
   assign bus.out_data  = s2_data_reg;
   assign bus.out_tag   = s2_tag_reg;

   shift_stage #(.WIDTH(WIDTH), .BIT_LO(0), .BIT_HI(LO_W - 1)) u_stage_lo (
      .data_in  (bus.in_data),
      .shamt    (bus.in_shamt[LO_W-1:0]),
      .mode     (bus.in_mode),
      .sign     (bus.in_data[WIDTH-1]),
      .data_out (s1_data_next)
   );

   shift_stage #(.WIDTH(WIDTH), .BIT_LO(LO_W), .BIT_HI(SHAMT_W - 1)) u_stage_hi (
      .data_in  (s1_data_reg),
      .shamt    (s1_shamt_reg),
      .mode     (s1_mode_reg),
      .sign     (s1_sign_reg),
      .data_out (s2_data_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         s2_data_reg  <= '0;
         s2_tag_reg   <= '0;
      end else if (flush) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
               s2_data_reg <= s2_data_next;
               s2_tag_reg  <= s1_tag_reg;
            end
         end
         if (s1_adv) begin
            s1_valid_reg <= bus.in_valid;
         end
      end
   end

   // s1_load already excludes rst and flush through in_ready.
   always_ff @(posedge clk) begin
      if (s1_load) begin
         s1_data_reg  <= s1_data_next;
         s1_shamt_reg <= bus.in_shamt[SHAMT_W-1:LO_W];
         s1_mode_reg  <= bus.in_mode;
         s1_sign_reg  <= bus.in_data[WIDTH-1];
         s1_tag_reg   <= bus.in_tag;
      end
   end
endmodule

// File: tb/tb_pipe_shifter.sv
// Directed self-checking bench for pipe_shifter: single ops per mode, edge
// shift amounts, backpressure, streaming, flush and mid-flight reset.
module tb_pipe_shifter;
   import pipe_shifter_pkg::*;

   localparam int WIDTH = 32;
   localparam int TAG_W = 5;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   pipe_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

   pipe_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] d,
                        input logic [4:0] s, input logic [4:0] t);
      bus.in_valid = v;
      bus.in_mode  = m;
      bus.in_data  = d;
      bus.in_shamt = s;
      bus.in_tag   = t;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // One operation through an empty pipe with out_ready=1.
   task automatic run_one(input string name, input logic [1:0] m, input logic [31:0] d,
                          input logic [4:0] s, input logic [4:0] t, input logic [31:0] exp);
      bus.out_ready = 1'b1;
      drive(1'b1, m, d, s, t);
      settle();
      chk({name, "/in_ready"}, 64'(bus.in_ready), 64'd1);
      tick();
      drive(1'b0, MODE_SLL, 32'd0, 5'd0, 5'd0);
      settle();
      chk({name, "/lat1_valid"}, 64'(bus.out_valid), 64'd0);
      tick();
      settle();
      chk({name, "/valid"}, 64'(bus.out_valid), 64'd1);
      chk({name, "/data"}, 64'(bus.out_data), 64'(exp));
      chk({name, "/tag"}, 64'(bus.out_tag), 64'(t));
      $display("[TB] %s: mode=%0d data=0x%08h shamt=%0d tag=%0d -> 0x%08h tag=%0d",
               name, m, d, s, t, bus.out_data, bus.out_tag);
      tick();
      settle();
      chk({name, "/drained"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      rst           = 1'b1;
      flush         = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b1, MODE_SLL, 32'h1, 5'd1, 5'd3);
      settle();
      chk("reset/in_ready_low", 64'(bus.in_ready), 64'd0);
      tick();
      chk("reset/in_ready_low2", 64'(bus.in_ready), 64'd0);
      drive(1'b0, MODE_SLL, 32'h0, 5'd0, 5'd0);
      tick();
      rst = 1'b0;
      settle();
      chk("reset/out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset/out_data", 64'(bus.out_data), 64'd0);
      chk("reset/out_tag", 64'(bus.out_tag), 64'd0);

      // Mode coverage and shift-amount boundaries
      run_one("sll_by2",    MODE_SLL, 32'h0000_0001, 5'd2,  5'd7,  32'h0000_0004);
      run_one("sra_neg4",   MODE_SRA, 32'h8000_0000, 5'd4,  5'd1,  32'hF800_0000);
      run_one("srl_4",      MODE_SRL, 32'h8000_0000, 5'd4,  5'd2,  32'h0800_0000);
      run_one("ror_1",      MODE_ROR, 32'h0000_0001, 5'd1,  5'd3,  32'h8000_0000);
      run_one("sll_31",     MODE_SLL, 32'h0000_0001, 5'd31, 5'd4,  32'h8000_0000);
      run_one("sra_0",      MODE_SRA, 32'h1234_5678, 5'd0,  5'd5,  32'h1234_5678);
      run_one("ror_0",      MODE_ROR, 32'h1234_5678, 5'd0,  5'd6,  32'h1234_5678);
      run_one("ror_8",      MODE_ROR, 32'h1234_5678, 5'd8,  5'd8,  32'h7812_3456);
      run_one("ror_3",      MODE_ROR, 32'h8000_0001, 5'd3,  5'd9,  32'h3000_0000);
      run_one("sra_31",     MODE_SRA, 32'h8000_0001, 5'd31, 5'd10, 32'hFFFF_FFFF);
      run_one("sra_30",     MODE_SRA, 32'hC000_0000, 5'd30, 5'd11, 32'hFFFF_FFFF);
      run_one("sra_pos5",   MODE_SRA, 32'h7FFF_FFFF, 5'd5,  5'd12, 32'h03FF_FFFF);
      run_one("srl_31",     MODE_SRL, 32'hF000_0000, 5'd31, 5'd13, 32'h0000_0001);
      run_one("sll_17",     MODE_SLL, 32'hFFFF_FFFF, 5'd17, 5'd14, 32'hFFFE_0000);

      // Backpressure: two ops fill the pipe, the third waits
      bus.out_ready = 1'b0;
      drive(1'b1, MODE_SLL, 32'h3, 5'd1, 5'd1);
      settle();
      chk("bp/accept_a", 64'(bus.in_ready), 64'd1);
      tick();
      drive(1'b1, MODE_SRL, 32'h100, 5'd4, 5'd2);
      settle();
      chk("bp/accept_b", 64'(bus.in_ready), 64'd1);
      tick();
      drive(1'b1, MODE_ROR, 32'hF, 5'd4, 5'd3);
      settle();
      chk("bp/stall_c", 64'(bus.in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp/hold_ready", 64'(bus.in_ready), 64'd0);
         chk("bp/hold_valid", 64'(bus.out_valid), 64'd1);
         chk("bp/hold_data", 64'(bus.out_data), 64'h6);
         chk("bp/hold_tag", 64'(bus.out_tag), 64'd1);
      end
      bus.out_ready = 1'b1;
      settle();
      chk("bp/accept_c", 64'(bus.in_ready), 64'd1);
      $display("[TB] bp: result tag=%0d data=0x%08h", bus.out_tag, bus.out_data);
      tick();
      drive(1'b0, MODE_SLL, 32'h0, 5'd0, 5'd0);
      settle();
      chk("bp/b_valid", 64'(bus.out_valid), 64'd1);
      chk("bp/b_data", 64'(bus.out_data), 64'h10);
      chk("bp/b_tag", 64'(bus.out_tag), 64'd2);
      $display("[TB] bp: result tag=%0d data=0x%08h", bus.out_tag, bus.out_data);
      tick();
      chk("bp/c_valid", 64'(bus.out_valid), 64'd1);
      chk("bp/c_data", 64'(bus.out_data), 64'hF000_0000);
      chk("bp/c_tag", 64'(bus.out_tag), 64'd3);
      $display("[TB] bp: result tag=%0d data=0x%08h", bus.out_tag, bus.out_data);
      tick();
      chk("bp/empty", 64'(bus.out_valid), 64'd0);

      // Streaming: op k is SLL (k+1) by k, tag k+10; result k appears in cycle k+2
      for (int c = 0; c < 11; c++) begin
         if (c < 8) drive(1'b1, MODE_SLL, 32'(c + 1), 5'(c), 5'(c + 10));
         else       drive(1'b0, MODE_SLL, 32'd0, 5'd0, 5'd0);
         settle();
         chk("stream/in_ready", 64'(bus.in_ready), 64'd1);
         chk("stream/out_valid", 64'(bus.out_valid), 64'(c >= 2 && c < 10));
         if (c >= 2 && c < 10) begin
            chk("stream/data", 64'(bus.out_data), 64'((c - 1) << (c - 2)));
            chk("stream/tag", 64'(bus.out_tag), 64'(c + 8));
            $display("[TB] stream: result tag=%0d data=0x%08h", bus.out_tag, bus.out_data);
         end
         tick();
      end

      // Flush with both stages full, an input pending and the consumer ready
      bus.out_ready = 1'b0;
      drive(1'b1, MODE_SLL, 32'h1, 5'd0, 5'd20);
      tick();
      drive(1'b1, MODE_SLL, 32'h2, 5'd0, 5'd21);
      tick();
      drive(1'b1, MODE_SLL, 32'h4, 5'd0, 5'd22);
      flush         = 1'b1;
      bus.out_ready = 1'b1;
      settle();
      chk("flush/pre_valid", 64'(bus.out_valid), 64'd1);
      chk("flush/pre_tag", 64'(bus.out_tag), 64'd20);
      chk("flush/in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      flush = 1'b0;
      drive(1'b0, MODE_SLL, 32'h0, 5'd0, 5'd0);
      settle();
      chk("flush/out_valid", 64'(bus.out_valid), 64'd0);
      $display("[TB] flush: out_valid=%0d after flush", bus.out_valid);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("flush/no_old", 64'(bus.out_valid), 64'd0);
      end

      // Reset with two operations in flight
      bus.out_ready = 1'b0;
      drive(1'b1, MODE_SRL, 32'hFFFF_0000, 5'd8, 5'd24);
      tick();
      drive(1'b1, MODE_SRL, 32'hFFFF_0000, 5'd12, 5'd25);
      tick();
      drive(1'b0, MODE_SLL, 32'h0, 5'd0, 5'd0);
      rst = 1'b1;
      settle();
      chk("rst/pre_valid", 64'(bus.out_valid), 64'd1);
      chk("rst/in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      rst = 1'b0;
      settle();
      chk("rst/out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst/out_data", 64'(bus.out_data), 64'd0);
      chk("rst/out_tag", 64'(bus.out_tag), 64'd0);
      $display("[TB] reset: out_valid=%0d out_data=0x%08h", bus.out_valid, bus.out_data);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rst/no_old", 64'(bus.out_valid), 64'd0);
      end

      run_one("after_rst", MODE_SLL, 32'h0000_0001, 5'd2, 5'd7, 32'h0000_0004);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits (power of two, 8 or more).
REQ-002 The block SHALL have parameter TAG_W, default 5, meaning the width of the sideband tag carried with each operation (destination register id).
REQ-003 The block SHALL define localparam SHAMT_W = clog2(WIDTH), meaning the shift amount width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have the following ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discards all in-flight operations (pipeline flush).
- in_valid  input  1  an operation is presented.
- in_ready  output  1  the block accepts an operation this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount.
- in_mode  input  2  operation: SLL=0, SRL=1, SRA=2, ROR=3.
- in_tag  input  TAG_W  sideband tag, passed through unchanged.
- out_valid  output  1  a result is presented.
- out_ready  input  1  the consumer accepts the result this cycle.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the result.

Function
REQ-006 A transfer SHALL occur on a port in any cycle where its valid and ready are both 1 at the rising clk edge.
REQ-007 The datapath SHALL be two register stages: S1 applies the low half of the shamt bits [SHAMT_W/2-1:0], and S2 applies the high bits.
REQ-008 Latency SHALL be exactly 2 cycles from input transfer to out_valid when there is no backpressure.
REQ-009 Throughput SHALL be 1 operation per cycle while out_ready=1.
REQ-010 Each stage SHALL hold a valid bit, partial data, remaining shamt, mode and tag.
REQ-011 S2 SHALL advance when it is empty or out_ready=1; S1 SHALL advance when it is empty or S2 advances.
REQ-012 in_ready SHALL equal the S1 advance condition and SHALL be combinational from out_ready, with no combinational path from in_valid.
REQ-013 While out_valid=1 and out_ready=0, out_data and out_tag SHALL hold stable.
REQ-014 Under backpressure the block SHALL hold at most 2 operations, and no operation SHALL be dropped or duplicated.
REQ-015 SLL SHALL zero-fill from the LSB, SRL SHALL zero-fill from the MSB, SRA SHALL fill with the original operand MSB, and ROR SHALL rotate right; the SRA sign bit SHALL be captured in S1.
REQ-016 A shamt of 0 SHALL return the operand unchanged in all modes.
REQ-017 The maximum shamt, WIDTH-1, SHALL be legal; for example SLL of 1 by 31 gives 0x80000000.
REQ-018 flush=1 SHALL clear both stage valid bits at the next edge, and in_ready SHALL be 0 in the flush cycle, so no input is accepted.
REQ-019 flush SHALL take priority over a simultaneous input or output transfer; out_valid SHALL be 0 the cycle after flush.
REQ-020 Data and tag registers SHALL load only when their stage advances with valid input, and SHALL otherwise hold.

Reset
REQ-021 On rst=1 at the clk edge, both stage valid bits SHALL clear.
REQ-022 In the cycle after reset, out_valid SHALL be 0, out_data SHALL be 0 and out_tag SHALL be 0.
REQ-023 in_ready SHALL be 0 while rst=1.
REQ-024 rst SHALL take priority over flush and over any transfer; operations in flight when reset is asserted SHALL be lost and SHALL never appear on the output.

Structure
REQ-025 A shared package SHALL hold the mode encoding constants (SLL, SRL, SRA, ROR) and a clog2 function.
REQ-026 The partial shifter, shift_stage, SHALL be one combinational sub-module instantiated twice, with parameters WIDTH and BIT_LO/BIT_HI selecting which shamt bits it applies.
REQ-027 The fixed shift-left-by-2 used for branch offsets SHALL be reproducible as mode SLL with shamt 2.

Verification
REQ-028 The bench SHALL cover: SLL, 0x00000001, shamt 2, tag 7 -> 0x00000004 with tag 7, two cycles after accept.
REQ-029 The bench SHALL cover: SRA 0x80000000 by 4 -> 0xF8000000; SRL 0x80000000 by 4 -> 0x08000000; ROR 0x00000001 by 1 -> 0x80000000.
REQ-030 The bench SHALL cover backpressure: out_ready=0 with 3 consecutive valid inputs -> 2 accepted, then in_ready=0. out_data holds stable. After out_ready=1 the results appear in order, with none lost.
REQ-031 The bench SHALL cover back-to-back streaming: 8 operations with out_ready=1 -> 8 results on consecutive cycles, with the first result 2 cycles after the first accept.
REQ-032 The bench SHALL cover flush: flush with both stages full and in_valid=1 -> out_valid=0 next cycle, the input is not accepted, and no old tag ever appears.
REQ-033 The bench SHALL cover reset mid-operation: rst with 2 operations in flight -> out_valid=0, out_data=0, and neither result emerges afterward.
